mc8051_mem_seq: RTL and testbench

Machine-cycle memory sequencer for the mc8051 core. It owns the S1..S6 stage counter and issues one bus transaction per enabled slot:
- S1 opcode fetch at PC
- S2 read and S3 read at the addresses produced by the operand/address mux
- S5 write of the muxed write data

Read data is captured into the S1 instruction buffer and the S2/S3 data buffers, which feed the mux and the ALU. The sequencer stalls the stage counter until the bus acknowledges.

---
 rtl/mc8051_mem_seq_pkg.sv | 29 ++
 rtl/mc8051_mem_seq.sv | 150 +++++++++++++++
 tb/tb_mc8051_mem_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc8051_mem_seq_pkg.sv
// Shared types for the mc8051 machine-cycle memory sequencer.
// Stage and sub-phase encodings, bus widths and the stage successor helper.
package mc8051_mem_seq_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    ST_S1 = 3'd0,
    ST_S2 = 3'd1,
    ST_S3 = 3'd2,
    ST_S4 = 3'd3,
    ST_S5 = 3'd4,
    ST_S6 = 3'd5
  } stage_e;

  typedef enum logic {
    SUB_ISSUE = 1'b0,
    SUB_WAIT  = 1'b1
  } sub_e;

  // S6 wraps back to S1 to start the next machine cycle.
  function automatic stage_e next_stage(input stage_e s);
    if (s == ST_S6) return ST_S1;
    return stage_e'(STAGE_W'(s) + STAGE_W'(1));
  endfunction

endpackage

// File: rtl/mc8051_mem_seq.sv
// Machine-cycle memory sequencer: walks S1..S6, issuing one bus access per
// enabled slot and stalling the stage counter until the bus acknowledges.
module mc8051_mem_seq
  import mc8051_mem_seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hold,
  input  logic              i_s1_fetch_en,
  input  logic              i_s2_rd_en,
  input  logic              i_s3_rd_en,
  input  logic              i_s5_wr_en,
  input  logic [7:0]        i_pch,
  input  logic [7:0]        i_pcl,
  input  logic [ADDR_W-1:0] i_s2_mem_addr_d,
  input  logic [ADDR_W-1:0] i_s3_mem_addr_d,
  input  logic [ADDR_W-1:0] i_s5_mem_addr_d,
  input  logic [DATA_W-1:0] i_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [STAGE_W-1:0] o_stage,
  output logic              o_stage_adv,
  output logic              o_mc_end,
  output logic [DATA_W-1:0] o_s1_instr_buffer,
  output logic [DATA_W-1:0] o_s2_data_buffer,
  output logic [DATA_W-1:0] o_s3_data_buffer
);

  stage_e stage_q, stage_d;
  sub_e   sub_q, sub_d;

  logic              slot_en_c;
  logic [ADDR_W-1:0] slot_addr_c;
  logic              issue_c;
  logic              done_c;
  logic              adv_c;

  logic              req_d, we_d, adv_d, mc_end_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, b1_d, b2_d, b3_d;

  // Per-slot enable and address selection; S4/S6 never issue.
  always_comb begin
    slot_en_c   = 1'b0;
    slot_addr_c = '0;
    case (stage_q)
      ST_S1: begin slot_en_c = i_s1_fetch_en; slot_addr_c = {i_pch, i_pcl}; end
      ST_S2: begin slot_en_c = i_s2_rd_en;    slot_addr_c = i_s2_mem_addr_d; end
      ST_S3: begin slot_en_c = i_s3_rd_en;    slot_addr_c = i_s3_mem_addr_d; end
      ST_S5: begin slot_en_c = i_s5_wr_en;    slot_addr_c = i_s5_mem_addr_d; end
      default: begin slot_en_c = 1'b0;        slot_addr_c = '0; end
    endcase
  end

  assign issue_c = (sub_q == SUB_ISSUE) && !i_hold && slot_en_c;
  assign done_c  = (sub_q == SUB_WAIT) && i_mem_ack;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= ST_S1;
      sub_q   <= SUB_ISSUE;
    end else begin
      stage_q <= stage_d;
      sub_q   <= sub_d;
    end
  end

  // Next-state logic; hold only matters in ISSUE.
  always_comb begin
    stage_d = stage_q;
    sub_d   = sub_q;
    adv_c   = 1'b0;
    if (sub_q == SUB_ISSUE) begin
      if (!i_hold) begin
        if (slot_en_c) begin
          sub_d = SUB_WAIT;
        end else begin
          stage_d = next_stage(stage_q);
          adv_c   = 1'b1;
        end
      end
    end else if (i_mem_ack) begin
      stage_d = next_stage(stage_q);
      sub_d   = SUB_ISSUE;
      adv_c   = 1'b1;
    end
  end

  // Next values for the registered bus outputs, pulses and read buffers.
  always_comb begin
    req_d    = o_mem_req;
    we_d     = o_mem_we;
    addr_d   = o_mem_addr;
    wdata_d  = o_mem_wdata;
    b1_d     = o_s1_instr_buffer;
    b2_d     = o_s2_data_buffer;
    b3_d     = o_s3_data_buffer;
    adv_d    = adv_c;
    mc_end_d = adv_c && (stage_q == ST_S6);
    if (issue_c) begin
      req_d  = 1'b1;
      we_d   = (stage_q == ST_S5);
      addr_d = slot_addr_c;
      if (stage_q == ST_S5) wdata_d = i_mem_wdata;
    end else if (done_c) begin
      req_d = 1'b0;
      we_d  = 1'b0;
      if (!o_mem_we) begin
        case (stage_q)
          ST_S1:   b1_d = i_mem_rdata;
          ST_S2:   b2_d = i_mem_rdata;
          ST_S3:   b3_d = i_mem_rdata;
          default: b1_d = o_s1_instr_buffer;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req         <= 1'b0;
      o_mem_we          <= 1'b0;
      o_mem_addr        <= '0;
      o_mem_wdata       <= '0;
      o_stage_adv       <= 1'b0;
      o_mc_end          <= 1'b0;
      o_s1_instr_buffer <= '0;
      o_s2_data_buffer  <= '0;
      o_s3_data_buffer  <= '0;
    end else begin
      o_mem_req         <= req_d;
      o_mem_we          <= we_d;
      o_mem_addr        <= addr_d;
      o_mem_wdata       <= wdata_d;
      o_stage_adv       <= adv_d;
      o_mc_end          <= mc_end_d;
      o_s1_instr_buffer <= b1_d;
      o_s2_data_buffer  <= b2_d;
      o_s3_data_buffer  <= b3_d;
    end
  end

  assign o_stage = STAGE_W'(stage_q);

endmodule

// File: tb/tb_mc8051_mem_seq.sv
// Self-checking bench for mc8051_mem_seq: directed machine-cycle vectors,
// hand-written corner sequences, and randomized cycles against a slot-cost model.
module tb_mc8051_mem_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_hold;
  logic        i_s1_fetch_en, i_s2_rd_en, i_s3_rd_en, i_s5_wr_en;
  logic [7:0]  i_pch, i_pcl;
  logic [15:0] i_s2_mem_addr_d, i_s3_mem_addr_d, i_s5_mem_addr_d;
  logic [7:0]  i_mem_wdata, i_mem_rdata;
  logic        i_mem_ack;
  logic        o_mem_req, o_mem_we;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic [2:0]  o_stage;
  logic        o_stage_adv, o_mc_end;
  logic [7:0]  o_s1_instr_buffer, o_s2_data_buffer, o_s3_data_buffer;

  int checks = 0;
  int errors = 0;

  mc8051_mem_seq dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hold(i_hold),
    .i_s1_fetch_en(i_s1_fetch_en), .i_s2_rd_en(i_s2_rd_en),
    .i_s3_rd_en(i_s3_rd_en), .i_s5_wr_en(i_s5_wr_en),
    .i_pch(i_pch), .i_pcl(i_pcl),
    .i_s2_mem_addr_d(i_s2_mem_addr_d), .i_s3_mem_addr_d(i_s3_mem_addr_d),
    .i_s5_mem_addr_d(i_s5_mem_addr_d), .i_mem_wdata(i_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_stage(o_stage), .o_stage_adv(o_stage_adv),
    .o_mc_end(o_mc_end), .o_s1_instr_buffer(o_s1_instr_buffer),
    .o_s2_data_buffer(o_s2_data_buffer), .o_s3_data_buffer(o_s3_data_buffer)
  );

  always #5 i_clk = ~i_clk;

  // One machine cycle: slot order S1,S2,S3,S5 in index 0..3.
  typedef struct {
    logic [3:0]       en;
    logic [3:0][15:0] addr;
    logic [7:0]       wdata;
    logic [3:0][7:0]  rdata;
    logic [3:0][1:0]  waits;
    int               hold_n;
    int               exp_cycles;
    logic [7:0]       exp_b1, exp_b2, exp_b3;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_req"}, 32'(o_mem_req), 0);
    chk({nm, "_we"}, 32'(o_mem_we), 0);
    chk({nm, "_addr"}, 32'(o_mem_addr), 0);
    chk({nm, "_wdata"}, 32'(o_mem_wdata), 0);
    chk({nm, "_stage"}, 32'(o_stage), 0);
    chk({nm, "_adv"}, 32'(o_stage_adv), 0);
    chk({nm, "_mcend"}, 32'(o_mc_end), 0);
    chk({nm, "_b1"}, 32'(o_s1_instr_buffer), 0);
    chk({nm, "_b2"}, 32'(o_s2_data_buffer), 0);
    chk({nm, "_b3"}, 32'(o_s3_data_buffer), 0);
  endtask

  // Acts as the bus and checks one machine cycle, starting in S1 ISSUE.
  task automatic run_mc(input vec_t v, input string nm);
    int  cyc = 0, held = 0, slot = 0, req_cnt = 0;
    bit  done = 0, in_req = 0, prev_hold = 0;
    i_s1_fetch_en = v.en[0]; i_s2_rd_en = v.en[1];
    i_s3_rd_en = v.en[2];    i_s5_wr_en = v.en[3];
    {i_pch, i_pcl} = v.addr[0];
    i_s2_mem_addr_d = v.addr[1]; i_s3_mem_addr_d = v.addr[2];
    i_s5_mem_addr_d = v.addr[3]; i_mem_wdata = v.wdata;
    i_hold = 0; i_mem_ack = 0;
    while (!done && cyc < 400) begin
      @(posedge i_clk); #1;
      cyc++;
      if (prev_hold) begin
        chk({nm, "_hold_stage"}, 32'(o_stage), 2);
        chk({nm, "_hold_adv"}, 32'(o_stage_adv), 0);
        chk({nm, "_hold_req"}, 32'(o_mem_req), 0);
      end
      prev_hold = 0;
      if (o_mem_req) begin
        if (!in_req) begin
          while (slot < 4 && !v.en[slot]) slot++;
          chk({nm, "_txn_expected"}, 32'(slot < 4), 1);
          if (slot > 3) slot = 3;
          chk({nm, "_txn_we"}, 32'(o_mem_we), 32'(slot == 3));
          if (slot == 3) chk({nm, "_txn_wdata"}, 32'(o_mem_wdata), 32'(v.wdata));
          in_req = 1; req_cnt = 0;
          // Disturb the active slot's mux inputs; they must not matter in WAIT.
          case (slot)
            0: {i_pch, i_pcl} = 16'($urandom);
            1: i_s2_mem_addr_d = 16'($urandom);
            2: i_s3_mem_addr_d = 16'($urandom);
            default: begin i_s5_mem_addr_d = 16'($urandom); i_mem_wdata = 8'($urandom); end
          endcase
        end
        chk({nm, "_txn_addr"}, 32'(o_mem_addr), 32'(v.addr[slot]));
        req_cnt++;
        i_mem_ack   = (req_cnt == int'(v.waits[slot]) + 1);
        i_mem_rdata = i_mem_ack ? v.rdata[slot] : 8'($urandom);
        i_hold      = 1'($urandom);
      end else begin
        if (in_req) begin
          chk({nm, "_req_len"}, 32'(req_cnt), 32'(int'(v.waits[slot]) + 1));
          in_req = 0; slot++;
        end
        i_hold = (o_stage == 3'd2) && (held < v.hold_n);
        if (i_hold) begin held++; prev_hold = 1; end
        // Ack without a pending request must be ignored.
        i_mem_ack   = 1'($urandom);
        i_mem_rdata = 8'($urandom);
      end
      if (o_mc_end) begin
        done = 1;
        chk({nm, "_end_stage"}, 32'(o_stage), 0);
        chk({nm, "_end_adv"}, 32'(o_stage_adv), 1);
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: no o_mc_end within %0d cycles", nm, cyc);
    end
    chk({nm, "_cycles"}, 32'(cyc), 32'(v.exp_cycles));
    chk({nm, "_b1"}, 32'(o_s1_instr_buffer), 32'(v.exp_b1));
    chk({nm, "_b2"}, 32'(o_s2_data_buffer), 32'(v.exp_b2));
    chk({nm, "_b3"}, 32'(o_s3_data_buffer), 32'(v.exp_b3));
    i_mem_ack = 0; i_hold = 0;
  endtask

  function automatic vec_t mk(input logic [3:0] en, input logic [15:0] a0, a1, a2, a3,
                              input logic [7:0] wd, input logic [7:0] r0, r1, r2,
                              input logic [1:0] w0, w1, w2, w3, input int hn, cyc,
                              input logic [7:0] b1, b2, b3);
    vec_t v;
    v.en = en; v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3;
    v.wdata = wd; v.rdata[0] = r0; v.rdata[1] = r1; v.rdata[2] = r2; v.rdata[3] = 8'h00;
    v.waits[0] = w0; v.waits[1] = w1; v.waits[2] = w2; v.waits[3] = w3;
    v.hold_n = hn; v.exp_cycles = cyc; v.exp_b1 = b1; v.exp_b2 = b2; v.exp_b3 = b3;
    return v;
  endfunction

  vec_t tbl[6];
  vec_t rv;
  logic [7:0] mb1, mb2, mb3;

  initial begin
    i_rst_n = 0; i_hold = 0; i_mem_ack = 0; i_mem_rdata = 0; i_mem_wdata = 0;
    i_s1_fetch_en = 0; i_s2_rd_en = 0; i_s3_rd_en = 0; i_s5_wr_en = 0;
    i_pch = 0; i_pcl = 0; i_s2_mem_addr_d = 0; i_s3_mem_addr_d = 0; i_s5_mem_addr_d = 0;

    // Expected cycles: 6 plus, per enabled slot, 1 + wait count, plus hold cycles.
    tbl[0] = mk(4'b0000, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 6, 8'h00, 8'h00, 8'h00);
    tbl[1] = mk(4'b0001, 16'h0123, 0, 0, 0, 8'h00, 8'hE5, 0, 0, 0, 0, 0, 0, 0, 7,
                8'hE5, 8'h00, 8'h00);
    tbl[2] = mk(4'b1110, 0, 16'h0030, 16'h0081, 16'h0040, 8'h3C, 0, 8'h5A, 8'hA5,
                0, 0, 0, 0, 0, 9, 8'hE5, 8'h5A, 8'hA5);
    tbl[3] = mk(4'b0010, 0, 16'h0033, 0, 0, 8'h00, 0, 8'h77, 0, 0, 3, 0, 0, 0, 10,
                8'hE5, 8'h77, 8'hA5);
    tbl[4] = mk(4'b0100, 0, 0, 16'h0090, 0, 8'h00, 0, 0, 8'h99, 0, 0, 0, 0, 5, 12,
                8'hE5, 8'h77, 8'h99);
    tbl[5] = mk(4'b1111, 16'hBEEF, 16'h1234, 16'h5678, 16'h9ABC, 8'hC3, 8'h11, 8'h22,
                8'h33, 0, 0, 0, 0, 0, 10, 8'h11, 8'h22, 8'h33);

    repeat (2) @(posedge i_clk);
    #1 check_reset_outputs("reset");
    i_rst_n = 1;

    // Idle machine cycle: stage walks 1..5 then wraps, mc_end only on the wrap.
    for (int k = 1; k <= 6; k++) begin
      @(posedge i_clk); #1;
      chk("idle_stage", 32'(o_stage), 32'(k % 6));
      chk("idle_adv", 32'(o_stage_adv), 1);
      chk("idle_mcend", 32'(o_mc_end), 32'(k == 6));
    end

    for (int t = 0; t < 6; t++) run_mc(tbl[t], $sformatf("vec%0d", t));

    // Spurious ack while held in S1 ISSUE: no capture, no advance.
    i_s1_fetch_en = 1; i_hold = 1; i_mem_ack = 1; i_mem_rdata = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      chk("spur_stage", 32'(o_stage), 0);
      chk("spur_req", 32'(o_mem_req), 0);
      chk("spur_adv", 32'(o_stage_adv), 0);
      chk("spur_b1", 32'(o_s1_instr_buffer), 32'(8'h11));
    end
    i_hold = 0; i_mem_ack = 0;

    // Randomized machine cycles against the slot-cost model.
    mb1 = 8'h11; mb2 = 8'h22; mb3 = 8'h33;
    for (int t = 0; t < 40; t++) begin
      rv.en = 4'($urandom);
      for (int s = 0; s < 4; s++) begin
        rv.addr[s] = 16'($urandom); rv.rdata[s] = 8'($urandom); rv.waits[s] = 2'($urandom);
      end
      rv.wdata = 8'($urandom);
      rv.hold_n = int'($urandom_range(0, 3));
      rv.exp_cycles = 6 + rv.hold_n;
      for (int s = 0; s < 4; s++)
        if (rv.en[s]) rv.exp_cycles += 1 + int'(rv.waits[s]);
      if (rv.en[0]) mb1 = rv.rdata[0];
      if (rv.en[1]) mb2 = rv.rdata[1];
      if (rv.en[2]) mb3 = rv.rdata[2];
      rv.exp_b1 = mb1; rv.exp_b2 = mb2; rv.exp_b3 = mb3;
      run_mc(rv, $sformatf("rnd%0d", t));
    end

    // Reset during S5 WAIT drops req asynchronously and clears everything.
    i_s1_fetch_en = 0; i_s2_rd_en = 0; i_s3_rd_en = 0; i_s5_wr_en = 1;
    i_s5_mem_addr_d = 16'h0040; i_mem_wdata = 8'h3C; i_mem_ack = 0;
    begin
      int n = 0;
      while (!o_mem_req && n < 20) begin @(posedge i_clk); #1; n++; end
    end
    chk("rstw_req_up", 32'(o_mem_req), 1);
    chk("rstw_we", 32'(o_mem_we), 1);
    chk("rstw_stage", 32'(o_stage), 4);
    #2 i_rst_n = 0;
    #1 check_reset_outputs("rstw");
    i_rst_n = 1; i_s5_wr_en = 0;
    run_mc(mk(4'b0000, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 6, 8'h00, 8'h00, 8'h00),
           "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
